conv_stream_engine: RTL and testbench
=====================================

// Module: conv_stream_engine
// PURPOSE
//  Parametrised single-clock successor to the 4-tap, 3-bit convolution engine.
//  - Accepts two LEN-sample sequences h (in_data1) and x (in_data2) under a valid/ready handshake.
//  - Emits the 2*LEN-1 point linear convolution y = x*h serially on out_data.
//  - Sits downstream of the CDC stage, entirely in the compute clock domain.
// PARAMETERS
//  DW   3  input sample width, unsigned
//  LEN  4  samples per sequence, LEN >= 2
//  OW   2*DW+$clog2(LEN)  output width (localparam, not overridable); overflow impossible
// PORTS
//  clk        in   1    compute clock; all state updates on posedge
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    in_data1/in_data2 carry a sample pair this cycle
//  in_ready   out  1    engine accepts a pair this cycle
//  in_data1   in   DW   h sample, first accepted = h[0]
//  in_data2   in   DW   x sample, first accepted = x[0]
//  mode       in   1    0 = convolution, 1 = correlation (only with CONV_CORR_EN)
//  out_valid  out  1    out_data holds y[k]
//  out_last   out  1    high with y[2*LEN-2]
//  out_data   out  OW   result sample
// BEHAVIOUR
//  - Reset: state IDLE; sample index 0; out_valid, out_last, out_data = 0; in_ready = 1.
//  - Sample stores are not reset; they are fully rewritten before use.
//  - Accept: in_valid && in_ready at posedge stores the pair at index cnt; cnt increments.
//  - FSM: IDLE -> LOAD on first accept; LOAD -> CALC when the LEN-th pair is accepted.
//  - FSM: CALC -> OUT after 1 cycle; OUT -> IDLE after 2*LEN-1 output cycles.
//  - in_ready = 1 in IDLE/LOAD, 0 in CALC/OUT; in_valid while not ready is ignored, no error.
//  - Gaps: in_valid may drop during LOAD; the engine holds cnt and waits indefinitely.
//  - Latency: last pair accepted at edge T -> y[0] valid in cycle T+2.
//    y[k] follows in consecutive cycles, no bubbles.
//  - Output: out_valid high exactly 2*LEN-1 consecutive cycles; out_last with the final sample.
//  - Next cycle out_valid = 0, out_data = 0, and in_ready returns to 1.
//  - Arithmetic: y[k] = sum over i+j=k of x[i]*h[j], 0<=i,j<LEN, unsigned, OW-bit result.
//  - Each product is 2*DW bits; the sum is exact.
//  - Output index counter runs 0..2*LEN-2 with no wrap; it is cleared on entering CALC.
//  - Mid-operation reset, any state: immediate return to reset values.
//    A partial frame is discarded; the next frame starts at index 0.
//  - No frame-abort input; a partial frame persists until completed or reset.
// CONFIGURATION
//  CONV_CORR_EN defined:
//  - mode is sampled on the first accepted pair of a frame and held for that frame.
//  - Mid-frame changes to mode are ignored.
//  - mode = 1 computes y[k] = sum over i+j=k of x[i]*h[LEN-1-j] (correlation, h reversed).
//  - Same latency and framing as convolution.
//  CONV_CORR_EN undefined:
//  - mode is ignored and the engine always convolves.
//  - No reversal mux is synthesised.
// TESTING (DW=3, LEN=4 unless noted)
//  1 All-max: h = x = 7,7,7,7 back-to-back.
//    -> y = 49,98,147,196,147,98,49; first out_valid 2 cycles after last accept; out_last on 49.
//  2 Impulse: h = 1,2,3,4, x = 1,0,0,0, mode = 0.
//    -> y = 1,2,3,4,0,0,0.
//  3 Correlation (CONV_CORR_EN): as test 2 with mode = 1, mode toggled mid-frame.
//    -> y = 4,3,2,1,0,0,0.
//    Without the macro: y = 1,2,3,4,0,0,0.
//  4 Gapped input: same data as test 1, in_valid low 3 cycles between each pair.
//    -> identical y; in_ready = 1 throughout LOAD.
//  5 Busy: in_valid held high through CALC/OUT with data 5.
//    -> in_ready = 0, y unchanged.
//    -> new frame starts only on the cycle after out_last; second frame all 5s gives 25,50,75,100,75,50,25.
//  6 Reset: rst pulsed during OUT after y[2].
//    -> out_valid = 0, out_data = 0, in_ready = 1 immediately.
//    -> a fresh frame then yields correct y.
//    Repeat the pulse mid-LOAD after 2 pairs: the stale pairs are not reused.

Source files
------------

// File: rtl/conv_stream_engine.sv
// -----------------------------------------------------------------------------
// conv_stream_engine
//   Streaming linear-convolution engine in a single compute clock domain.
//   Collects two LEN-sample sequences h and x through a valid/ready handshake,
//   then emits the 2*LEN-1 point result y = x*h serially, one sample per cycle.
//
//   Optional feature macro: CONV_CORR_EN
//     defined   : mode (sampled on the first pair of a frame) selects
//                 0 = convolution, 1 = correlation (h reversed).
//     undefined : mode is ignored, the engine always convolves and no
//                 reversal mux is built.
//
// Ports
//   clk       in   1   compute clock, all state changes on posedge
//   rst       in   1   asynchronous active-high reset
//   in_valid  in   1   sample pair present on in_data1/in_data2
//   in_ready  out  1   engine accepts a pair this cycle (IDLE/LOAD)
//   in_data1  in   DW  h sample, first accepted = h[0]
//   in_data2  in   DW  x sample, first accepted = x[0]
//   mode      in   1   0 = convolution, 1 = correlation (CONV_CORR_EN only)
//   out_valid out  1   out_data holds y[k]
//   out_last  out  1   high together with y[2*LEN-2]
//   out_data  out  OW  result sample, OW = 2*DW + clog2(LEN)
// -----------------------------------------------------------------------------
module conv_stream_engine #(
  parameter int DW  = 3,
  parameter int LEN = 4,
  localparam int OW = 2 * DW + $clog2(LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data1,
  input  logic [DW-1:0] in_data2,
  input  logic          mode,
  output logic          out_valid,
  output logic          out_last,
  output logic [OW-1:0] out_data
);

  localparam int CW   = $clog2(LEN);
  localparam int NOUT = 2 * LEN - 1;
  localparam int KW   = $clog2(NOUT);

  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(NOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [KW-1:0] kidx;
  logic [DW-1:0] h_mem [LEN];
  logic [DW-1:0] x_mem [LEN];
  logic [DW-1:0] h_eff [LEN];
  logic [OW-1:0] y_k;
  logic          accept;

  assign accept = in_valid && in_ready;

`ifdef CONV_CORR_EN
  logic mode_r;

  // Frame mode: latched on the first accepted pair, held for the whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r <= 1'b0;
    end else if (accept && (state == S_IDLE)) begin
      mode_r <= mode;
    end
  end

  // Tap order: correlation walks h from its far end.
  always_comb begin
    for (int j = 0; j < LEN; j++) begin
      h_eff[j] = mode_r ? h_mem[LEN-1-j] : h_mem[j];
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  // Tap order: plain convolution only.
  always_comb begin
    for (int j = 0; j < LEN; j++) begin
      h_eff[j] = h_mem[j];
    end
  end
`endif

  // Sample stores: no reset needed, every slot is rewritten before a frame is used.
  always_ff @(posedge clk) begin
    if (accept) begin
      h_mem[cnt] <= in_data1;
      x_mem[cnt] <= in_data2;
    end
  end

  // Output sample y[kidx]: exact sum of products on the anti-diagonal i+j=kidx.
  always_comb begin
    y_k = '0;
    for (int i = 0; i < LEN; i++) begin
      for (int j = 0; j < LEN; j++) begin
        if ((i + j) == int'(kidx)) begin
          y_k = y_k + OW'(x_mem[i]) * OW'(h_eff[j]);
        end
      end
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      kidx      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_IDLE, S_LOAD: begin
          if (accept) begin
            if (cnt == CNT_LAST) begin
              state    <= S_CALC;
              cnt      <= '0;
              kidx     <= '0;
              in_ready <= 1'b0;
            end else begin
              state <= S_LOAD;
              cnt   <= cnt + CW'(1);
            end
          end
        end
        S_CALC: begin
          state <= S_OUT;
        end
        S_OUT: begin
          // The cycle after out_last clears the outputs and reopens the input.
          if (out_last) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
          end else begin
            out_valid <= 1'b1;
            out_data  <= y_k;
            out_last  <= (kidx == K_LAST);
            if (kidx != K_LAST) begin
              kidx <= kidx + KW'(1);
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_engine.sv
// -----------------------------------------------------------------------------
// tb_conv_stream_engine
//   Self-checking bench for conv_stream_engine (DW=3, LEN=4).
//   Frames come from a table of {h, x, mode, gap, expected y}; expected samples
//   are queued when a frame is driven and compared as the engine emits them.
//   Hand-written sequences cover back-pressure and mid-frame resets.
// -----------------------------------------------------------------------------
module tb_conv_stream_engine;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_data1;
  logic [2:0] in_data2;
  logic       mode;
  logic       out_valid;
  logic       out_last;
  logic [7:0] out_data;

  conv_stream_engine #(.DW(3), .LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .mode      (mode),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // h, x and y are packed with index 0 as the rightmost element.
  typedef struct {
    logic [3:0][2:0] h;
    logic [3:0][2:0] x;
    logic            mode;
    int              gap;
    logic [6:0][7:0] y;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];
  vec_t fives;
  int   checks   = 0;
  int   failures = 0;
  int   n_out    = 0;
  logic prev_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_frame(input logic [6:0][7:0] y);
    exp_t e;
    for (int k = 0; k < 7; k++) begin
      e.data = y[k];
      e.last = (k == 6);
      sb.push_back(e);
    end
  endtask

  // Output monitor: pops the scoreboard on each valid sample.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          n_out++;
          chk("busy_ready", in_ready, 0);
          if (sb.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("y_data", out_data, e.data);
            chk("y_last", out_last, e.last);
          end
        end else begin
          chk("idle_data", out_data, 0);
        end
        if (prev_last) begin
          chk("after_last_ready", in_ready, 1);
          chk("after_last_valid", out_valid, 0);
        end
        prev_last = out_valid && out_last;
      end else begin
        prev_last = 1'b0;
      end
    end
  end

  // Drives one frame; starts and ends at #1 after a posedge.
  task automatic drive_frame(input vec_t v, input bit hold5);
    bit ok;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data1 = v.h[i];
      in_data2 = v.x[i];
      mode     = (i == 0) ? v.mode : ~v.mode;
      ok = 1'b0;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      if (i < 3 && v.gap > 0) begin
        in_valid = 1'b0;
        for (int g = 0; g < v.gap; g++) begin
          @(negedge clk);
          chk("gap_ready", in_ready, 1);
          @(posedge clk); #1;
        end
      end
    end
    if (hold5) begin
      in_valid = 1'b1;
      in_data1 = 3'd5;
      in_data2 = 3'd5;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // Called #1 after the last accepting edge T: y[0] appears after edge T+2.
  task automatic check_latency();
    @(negedge clk); chk("lat_cycle1", out_valid, 0);
    @(negedge clk); chk("lat_cycle2", out_valid, 0);
    @(negedge clk); chk("lat_cycle3", out_valid, 1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("frame_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    int base;
    bit ok;

    // Table: all-max, impulse, correlation request, gapped all-max, ramp.
    vecs[0].h = {3'd7, 3'd7, 3'd7, 3'd7}; vecs[0].x = {3'd7, 3'd7, 3'd7, 3'd7};
    vecs[0].mode = 1'b0; vecs[0].gap = 0;
    vecs[0].y = {8'd49, 8'd98, 8'd147, 8'd196, 8'd147, 8'd98, 8'd49};
    vecs[1].h = {3'd4, 3'd3, 3'd2, 3'd1}; vecs[1].x = {3'd0, 3'd0, 3'd0, 3'd1};
    vecs[1].mode = 1'b0; vecs[1].gap = 0;
    vecs[1].y = {8'd0, 8'd0, 8'd0, 8'd4, 8'd3, 8'd2, 8'd1};
    vecs[2].h = {3'd4, 3'd3, 3'd2, 3'd1}; vecs[2].x = {3'd0, 3'd0, 3'd0, 3'd1};
    vecs[2].mode = 1'b1; vecs[2].gap = 0;
`ifdef CONV_CORR_EN
    vecs[2].y = {8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
`else
    vecs[2].y = {8'd0, 8'd0, 8'd0, 8'd4, 8'd3, 8'd2, 8'd1};
`endif
    vecs[3] = vecs[0]; vecs[3].gap = 3;
    vecs[4].h = {3'd4, 3'd3, 3'd2, 3'd1}; vecs[4].x = {3'd1, 3'd2, 3'd3, 3'd4};
    vecs[4].mode = 1'b0; vecs[4].gap = 0;
    vecs[4].y = {8'd4, 8'd11, 8'd20, 8'd30, 8'd20, 8'd11, 8'd4};
    fives.h = {3'd5, 3'd5, 3'd5, 3'd5}; fives.x = {3'd5, 3'd5, 3'd5, 3'd5};
    fives.mode = 1'b0; fives.gap = 0;
    fives.y = {8'd25, 8'd50, 8'd75, 8'd100, 8'd75, 8'd50, 8'd25};

    rst = 1'b1; in_valid = 1'b0; in_data1 = 3'd0; in_data2 = 3'd0; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      push_frame(vecs[v].y);
      drive_frame(vecs[v], 1'b0);
      check_latency();
      wait_done();
    end

    // Busy: in_valid stays high with 5s through CALC/OUT; the held pairs
    // only form the next frame once in_ready returns.
    push_frame(vecs[4].y);
    push_frame(fives.y);
    drive_frame(vecs[4], 1'b1);
    check_latency();
    acc = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
      if (acc == 4) break;
    end
    in_valid = 1'b0;
    chk("busy_accepts", acc, 4);
    check_latency();
    wait_done();

    // Reset during OUT, right after y[2] is presented.
    push_frame(vecs[0].y);
    drive_frame(vecs[0], 1'b0);
    base = n_out;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk); #1;
      if (n_out >= base + 3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_y2", ok, 1);
    rst = 1'b1;
    #1;
    chk("midout_valid", out_valid, 0);
    chk("midout_data", out_data, 0);
    chk("midout_ready", in_ready, 1);
    chk("midout_last", out_last, 0);
    sb.delete();
    @(posedge clk); #2; rst = 1'b0;
    @(posedge clk); #1;
    push_frame(vecs[1].y);
    drive_frame(vecs[1], 1'b0);
    check_latency();
    wait_done();

    // Reset mid-LOAD after two pairs; the next frame must start at index 0.
    in_valid = 1'b1; in_data1 = 3'd7; in_data2 = 3'd7;
    repeat (2) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk("midload_ready", in_ready, 1);
    @(posedge clk); #2; rst = 1'b0;
    @(posedge clk); #1;
    push_frame(vecs[4].y);
    drive_frame(vecs[4], 1'b0);
    check_latency();
    wait_done();

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
